// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC loop sequencer.
// State encoding plus a small sizing helper.
package mac_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_loop_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones once full.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_loop_sequencer.sv
// Run controller for a pipelined MAC kernel.
// Sequences clear, issue, drain and completion over global_rst/global_en.
module mac_loop_sequencer
  import mac_seq_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLEAR_CYCLES = 1,
  parameter int PIPE_DEPTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] trip_count,
  input  logic             stall_in,
  input  logic             abort,
  output logic             global_rst,
  output logic             global_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] iter_idx,
  output logic             iter_last,
  output logic [WIDTH-1:0] stall_cycles
);

  localparam int CNT_W =
    $clog2(max2(CLEAR_CYCLES, PIPE_DEPTH) + 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] trip_m1;
  logic [WIDTH-1:0] idx;
  logic             abort_q;

  logic st_clear;
  logic st_run;
  logic st_drain;
  logic active;
  logic launch;
  logic stall_inc;

  assign st_clear = (state == CLEAR);
  assign st_run   = (state == RUN);
  assign st_drain = (state == DRAIN);
  assign active   = st_clear | st_run | st_drain;

  assign launch    = (state == IDLE) & start & (trip_count != '0);
  assign stall_inc = (st_run | st_drain) & stall_in;

  // Compare against latched trip-1 so trip = all-ones never wraps.
  assign iter_last = st_run & (idx == trip_m1);
  assign iter_idx  = idx;

  // Abort flush cycle pulses reset and enable together.
  assign global_rst = st_clear | abort_q;
  assign global_en  = st_clear | abort_q |
                      ((st_run | st_drain) & ~stall_in);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign aborted    = abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      trip_m1 <= '0;
      idx     <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (abort && active) begin
        state   <= IDLE;
        abort_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (trip_count == '0) begin
                state <= DONE;
              end else begin
                trip_m1 <= trip_count - WIDTH'(1);
                idx     <= '0;
                cnt     <= CNT_W'(CLEAR_CYCLES);
                state   <= CLEAR;
              end
            end
          end
          CLEAR: begin
            if (cnt == CNT_W'(1)) state <= RUN;
            else cnt <= cnt - CNT_W'(1);
          end
          RUN: begin
            if (!stall_in) begin
              idx <= idx + WIDTH'(1);
              if (idx == trip_m1) begin
                cnt   <= CNT_W'(PIPE_DEPTH);
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (!stall_in) begin
              if (cnt == CNT_W'(1)) state <= DONE;
              else cnt <= cnt - CNT_W'(1);
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(launch),
    .inc  (stall_inc),
    .count(stall_cycles)
  );

endmodule
